// File: rtl/series_pkg.sv
// Shared constants and constant functions for the series-term controller and datapath.
// Pass count and counter widths come from the helpers below.
package series_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic int clog2(input int val);
        int r;
        int x;
        r = 0;
        x = val - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/series_seq_controller_if.sv
// Request/result handshake and datapath control bundle of the series sequencer.
// slave = controller side, master = requester/datapath side.
interface series_seq_controller_if #(
    parameter int STAGES = 3,
    parameter int PW     = 2
);
    logic              start;
    logic              abort;
    logic              overflow_in;
    logic              out_ready;
    logic              ready;
    logic              sel_load;
    logic [STAGES-1:0] term_en;
    logic [PW-1:0]     pass_idx;
    logic              last_pass;
    logic              out_valid;
    logic              error;
    logic              busy;

    modport master (
        output start, abort, overflow_in, out_ready,
        input  ready, sel_load, term_en, pass_idx, last_pass, out_valid, error, busy
    );

    modport slave (
        input  start, abort, overflow_in, out_ready,
        output ready, sel_load, term_en, pass_idx, last_pass, out_valid, error, busy
    );
endinterface

// File: rtl/series_pass_counter.sv
// Nested stage/pass counter; clr has priority over en; holds at the final stage of the final pass.
// Latency: registered counts, last_* flags decode the current count combinationally.
module series_pass_counter #(
    parameter int STAGES = 3,
    parameter int PASSES = 3,
    parameter int SW     = 2,
    parameter int PW     = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [PW-1:0] o_pass_cnt,
    output logic          o_last_stage,
    output logic          o_last_pass
);
    logic [SW-1:0] r_stage_cnt;
    logic [PW-1:0] r_pass_cnt;

    assign o_last_stage = (r_stage_cnt == SW'(STAGES - 1));
    assign o_last_pass  = (r_pass_cnt == PW'(PASSES - 1));
    assign o_pass_cnt   = r_pass_cnt;

    always_ff @(posedge clk) begin
        if (!rst || i_clr) begin
            r_stage_cnt <= '0;
            r_pass_cnt  <= '0;
        end else if (i_en && !o_last_stage) begin
            r_stage_cnt <= r_stage_cnt + SW'(1);
        end else if (i_en && !o_last_pass) begin
            r_stage_cnt <= '0;
            r_pass_cnt  <= r_pass_cnt + PW'(1);
        end
    end
endmodule

// File: rtl/series_seq_controller.sv
// Sequences ceil(N_TERMS/STAGES) recirculation passes; result valid PASSES*STAGES+1 cycles after accept.
// Result held until out_ready; accept of the next request may coincide with the result handshake.
module series_seq_controller
    import series_pkg::*;
#(
    parameter int N_TERMS = 7,
    parameter int STAGES  = 3
) (
    input  logic clk,
    input  logic rst,
    series_seq_controller_if.slave bus
);
    localparam int PASSES = ceil_div(N_TERMS, STAGES);
    localparam int PW     = max_int(1, clog2(PASSES));
    localparam int SW     = max_int(1, clog2(STAGES));

    state_t            r_state;
    logic              r_out_valid;
    logic              r_error;
    logic              r_busy;
    logic              w_ready;
    logic              w_accept;
    logic [PW-1:0]     w_pass_cnt;
    logic              w_last_stage;
    logic              w_last_pass;
    logic [STAGES-1:0] w_term_en;

    assign w_ready  = !bus.abort && ((r_state == ST_IDLE) ||
                      (((r_state == ST_DONE) || (r_state == ST_ERR)) && bus.out_ready));
    assign w_accept = w_ready && bus.start;

    // Counters are held at zero outside RUN so every new request starts from pass 0.
    series_pass_counter #(
        .STAGES (STAGES),
        .PASSES (PASSES),
        .SW     (SW),
        .PW     (PW)
    ) u_pass_counter (
        .clk          (clk),
        .rst          (rst),
        .i_clr        ((r_state != ST_RUN) || bus.abort),
        .i_en         (r_state == ST_RUN),
        .o_pass_cnt   (w_pass_cnt),
        .o_last_stage (w_last_stage),
        .o_last_pass  (w_last_pass)
    );

    always_comb begin
        w_term_en = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_term_en[i] = r_busy && ((int'(w_pass_cnt) * STAGES + i) < N_TERMS);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || bus.abort) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_error     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Overflow on the final cycle still reports an error.
                    if (bus.overflow_in) begin
                        r_state     <= ST_ERR;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_error     <= 1'b1;
                    end else if (w_last_stage && w_last_pass) begin
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_error     <= 1'b0;
                    end
                end
                default: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_error     <= 1'b0;
                        if (bus.start) begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.ready     = w_ready;
    assign bus.sel_load  = w_accept;
    assign bus.term_en   = w_term_en;
    assign bus.pass_idx  = w_pass_cnt;
    assign bus.last_pass = r_busy && w_last_pass;
    assign bus.out_valid = r_out_valid;
    assign bus.error     = r_error;
    assign bus.busy      = r_busy;
endmodule

// File: doc/series_seq_controller.md
Name: series_seq_controller

Overview:
- Sequencing controller for the chained series-term datapath, generalised from the single-shot controller.
- The datapath has STAGES registered term units. A request of N_TERMS terms recirculates through them ceil(N_TERMS/STAGES) times.
- The controller owns:
  - the load/feedback select and per-pass stage enables;
  - sticky overflow-to-error reporting;
  - an output valid/ready handshake that allows back-to-back requests.

Parameters:
- N_TERMS, 7: total series terms per request; must be >= 1.
- STAGES, 3: cascaded term units in the datapath; must be >= 1.
- PASSES, derived ceil(N_TERMS/STAGES): recirculation passes; not user-overridable.
- PW, derived max(1, clog2(PASSES)): pass index width.
- SW, derived max(1, clog2(STAGES)): stage counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- start  in  1  request; accepted only when ready=1.
- abort  in  1  synchronous cancel of the current request.
- overflow_in  in  1  datapath overflow flag, valid each compute cycle.
- out_ready  in  1  downstream accepts the result.
- ready  out  1  controller can accept start this cycle.
- sel_load  out  1  1 = datapath loads external operands; 0 = feedback.
- term_en  out  STAGES  per-stage enable for the current pass.
- pass_idx  out  PW  current pass number, 0..PASSES-1.
- last_pass  out  1  current pass is PASSES-1.
- out_valid  out  1  result (or error) available.
- error  out  1  qualifies out_valid: the result overflowed.
- busy  out  1  request in flight (RUN state).

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE; counters=0.
  - Outputs: out_valid=0, error=0, sel_load=0, busy=0, term_en=0, pass_idx=0, last_pass=0.
  - ready=1 combinationally in IDLE, including the first cycle after reset.
- States: IDLE, RUN, DONE, ERR.
- ready = (IDLE) | ((DONE|ERR) & out_ready); combinational. Forced to 0 when abort=1.
- sel_load = ready & start. The accept cycle T is the load cycle.
- IDLE:
  - start=1 -> RUN, stage_cnt=0, pass_cnt=0.
  - otherwise stay in IDLE.
- RUN:
  - busy=1; sel_load=0.
  - stage_cnt increments every cycle.
  - At stage_cnt=STAGES-1:
    - if pass_cnt=PASSES-1 -> DONE;
    - else pass_cnt+1, stage_cnt=0.
- term_en[i] = busy & (pass_cnt*STAGES + i < N_TERMS), constant across a pass.
  - Only the last pass may have fewer stages enabled.
  - Example: N=7, S=3 -> pass 2 term_en=3'b001.
- Latency: RUN occupies exactly PASSES*STAGES cycles. out_valid first rises at T+PASSES*STAGES+1. Example: N=7, S=3 -> T+10.
- overflow_in:
  - sampled only in RUN; ignored in IDLE/DONE/ERR and in the load cycle;
  - on any RUN cycle -> ERR next cycle;
  - wins over the DONE transition on the final RUN cycle.
- DONE: out_valid=1, error=0, held stable until out_ready=1.
- ERR: out_valid=1, error=1, held stable until out_ready=1.
- On out_ready=1 in DONE/ERR:
  - start=1 -> RUN; back-to-back, no idle bubble; the new request's load cycle is the same cycle.
  - start=0 -> IDLE.
- abort=1 in any state -> IDLE next cycle, counters cleared, no out_valid.
  - abort wins over start, overflow_in and out_ready in the same cycle.
- start while busy or while holding an unaccepted result is ignored; no queueing.
- PASSES=1 (N_TERMS <= STAGES): RUN lasts STAGES cycles; last_pass=1 throughout.
- Counters never wrap: they are reset on every accept.
- Reset mid-RUN discards the request; the reset values above apply next cycle.

Decomposition:
- Shared package series_pkg:
  - state encoding constants (IDLE/RUN/DONE/ERR);
  - ceil_div and clog2 constant functions, used here and by the datapath for PASSES/PW.
- One sub-module, series_pass_counter: nested stage_cnt/pass_cnt with clear, enable, last_stage and last_pass outputs.

Test Plan:
- Reset behaviour: rst=0 for 2 cycles mid-RUN -> all outputs at reset values; ready=1 on the first cycle after rst=1.
- Nominal run (N=7, S=3): start at T -> sel_load=1 at T; busy T+1..T+9; pass_idx 0,0,0,1,1,1,2,2,2; term_en 111,111,001 per pass; out_valid=1, error=0 at T+10.
- Backpressure then back-to-back: hold out_ready=0 5 cycles -> out_valid stays 1. Then out_ready=1 with start=1 -> ready=1, sel_load=1 that cycle; next result 10 cycles later.
- Overflow: overflow_in=1 on the 4th RUN cycle -> ERR, out_valid=1 and error=1 next cycle. A pulse on the final RUN cycle also yields error=1 (precedence over DONE).
- Abort and ignored start: abort=1 with start=1 mid-RUN -> IDLE, no out_valid. start pulses during RUN -> no effect on counters.
- Single-pass config (N=2, S=4): start -> 4 RUN cycles, term_en=4'b0011, last_pass=1, out_valid at T+5.
